ap_ctrl_sequencer: RTL and testbench

Batch sequencer for one HLS kernel using the `ap_ctrl_chain` block protocol. It accepts a command "run N invocations" and drives `ap_start` and `ap_continue` with up to `MAX_OUT` invocations in flight. It counts issued and completed invocations and measures per-invocation latency. It sits between a host or register front-end and the kernel's block-control port, and its start/ready/done traffic is what the co-sim module and loop monitors sample.

---
 rtl/ap_ctrl_pkg.sv | 15 +
 rtl/ap_txn_ts_fifo.sv | 58 +++++
 rtl/ap_ctrl_sequencer.sv | 166 ++++++++++++++++
 tb/tb_ap_ctrl_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ap_ctrl_pkg.sv
// ap_ctrl_pkg: shared types and defaults for the
// ap_ctrl_chain batch sequencer.
package ap_ctrl_pkg;

  localparam int CNT_W_DEF   = 32;
  localparam int MAX_OUT_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/ap_txn_ts_fifo.sv
// ap_txn_ts_fifo: issue-timestamp FIFO, one entry
// per invocation in flight.
module ap_txn_ts_fifo
  import ap_ctrl_pkg::*;
#(
  parameter int DEPTH = MAX_OUT_DEF,
  parameter int W     = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  // a pop frees the slot, so push-on-full is fine
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= inc(wp);
      if (do_pop)  rp <= inc(rp);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/ap_ctrl_sequencer.sv
// ap_ctrl_sequencer: runs N ap_ctrl_chain invocations
// with bounded overlap and per-invocation latency stats.
module ap_ctrl_sequencer
  import ap_ctrl_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_abort,
  output logic             k_ap_start,
  input  logic             k_ap_ready,
  input  logic             k_ap_done,
  output logic             k_ap_continue,
  output logic             busy,
  output logic             done_pulse,
  output logic [CNT_W-1:0] txn_issued,
  output logic [CNT_W-1:0] txn_done,
  output logic [CNT_W-1:0] last_latency,
  output logic [CNT_W-1:0] max_latency
);

  seq_state_e       state;
  seq_state_e       state_nx;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] now;
  logic [CNT_W-1:0] ts;
  logic [CNT_W-1:0] lat;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] iss_after;
  logic [CNT_W-1:0] dn_after;
  logic [CNT_W-1:0] out_after;
  logic             accept;
  logic             issue;
  logic             done_raw;
  logic             done_ev;
  logic             ts_full;
  logic             ts_empty;
  logic             can_issue;
  logic             start_d;
  logic             ready_d;
  logic             busy_d;
  logic             pulse_d;

  assign accept   = cmd_valid & cmd_ready;
  assign issue    = k_ap_start & k_ap_ready;
  assign k_ap_continue =
    (state == S_RUN) | (state == S_DRAIN);
  assign done_raw = k_ap_done & k_ap_continue;

  assign outstanding = txn_issued - txn_done;
  // a done with nothing in flight is dropped
  assign done_ev =
    done_raw & (outstanding != '0) & ~ts_empty;

  assign iss_after = txn_issued + CNT_W'(issue);
  assign dn_after  = txn_done + CNT_W'(done_ev);
  assign out_after = iss_after - dn_after;
  assign lat       = now - ts;

  assign can_issue =
    (iss_after < target) &
    (out_after < CNT_W'(MAX_OUT)) &
    ~(ts_full & ~done_ev) &
    ~cmd_abort;

  ap_txn_ts_fifo #(
    .DEPTH (MAX_OUT),
    .W     (CNT_W)
  ) u_ts (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .push  (issue),
    .wdata (now),
    .pop   (done_ev),
    .rdata (ts),
    .full  (ts_full),
    .empty (ts_empty)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= S_IDLE;
      cmd_ready  <= 1'b0;
      k_ap_start <= 1'b0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_nx;
      cmd_ready  <= ready_d;
      k_ap_start <= start_d;
      busy       <= busy_d;
      done_pulse <= pulse_d;
    end
  end

  // an empty batch retires through DRAIN so its
  // done_pulse lands where a drained batch's would
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (accept)
          state_nx = (cmd_count == '0) ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        if ((iss_after == target) ||
            (cmd_abort && (!k_ap_start || issue)))
          state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (dn_after == txn_issued) state_nx = S_FIN;
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // a raised start is held until the kernel takes it
  always_comb begin
    start_d = 1'b0;
    ready_d = (state_nx == S_IDLE);
    busy_d  = (state_nx == S_RUN) | (state_nx == S_DRAIN);
    pulse_d = (state_nx == S_FIN);
    if (state_nx == S_RUN)
      start_d = (state == S_IDLE) |
                (k_ap_start & ~issue) |
                can_issue;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      now          <= '0;
      target       <= '0;
      txn_issued   <= '0;
      txn_done     <= '0;
      last_latency <= '0;
      max_latency  <= '0;
    end else begin
      now <= now + CNT_W'(1);
      if (accept) begin
        target      <= cmd_count;
        txn_issued  <= '0;
        txn_done    <= '0;
        max_latency <= '0;
      end else begin
        txn_issued <= iss_after;
        txn_done   <= dn_after;
        if (done_ev) begin
          last_latency <= lat;
          if (lat > max_latency) max_latency <= lat;
        end
      end
    end
  end

  a_spurious_done: assert property (
    @(posedge ap_clk) disable iff (!ap_rst_n)
    !(done_raw && outstanding == '0)
  );

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// tb_ap_ctrl_sequencer: directed batches against a
// behavioural ap_ctrl_chain kernel model.
module tb_ap_ctrl_sequencer;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_count;
  logic        cmd_abort;
  logic        k_ap_start;
  logic        k_ap_ready = 1'b0;
  logic        k_ap_done = 1'b0;
  logic        k_ap_continue;
  logic        busy;
  logic        done_pulse;
  logic [31:0] txn_issued;
  logic [31:0] txn_done;
  logic [31:0] last_latency;
  logic [31:0] max_latency;

  int checks = 0;
  int failures = 0;

  // kernel model
  int rdy_dly = 0;
  int dly [3];
  int age = 0;
  int due_q [$];
  int iss_n = 0;
  int dn_n = 0;
  int iss_base = 0;
  int cyc = 0;
  bit both_now = 0;

  // monitor
  int both_cnt = 0;
  int viol = 0;
  int pulse_cnt = 0;
  logic [31:0] prev_out = '0;

  typedef struct {
    int n;
    int rdy;
    int d0;
    int d1;
    int d2;
    int e_iss;
    int e_dn;
    int e_last;
    int e_max;
    bit both;
  } vec_t;

  vec_t vecs [5];
  vec_t rv;

  ap_ctrl_sequencer dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_count     (cmd_count),
    .cmd_abort     (cmd_abort),
    .k_ap_start    (k_ap_start),
    .k_ap_ready    (k_ap_ready),
    .k_ap_done     (k_ap_done),
    .k_ap_continue (k_ap_continue),
    .busy          (busy),
    .done_pulse    (done_pulse),
    .txn_issued    (txn_issued),
    .txn_done      (txn_done),
    .last_latency  (last_latency),
    .max_latency   (max_latency)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      age = 0;
      due_q.delete();
      iss_n = 0;
      dn_n = 0;
      both_now = 0;
    end else begin
      both_now = k_ap_start && k_ap_ready &&
                 k_ap_done && k_ap_continue;
      if (k_ap_start && k_ap_ready) begin
        due_q.push_back(cyc + dly[(iss_n - iss_base) % 3]);
        iss_n++;
        age = 0;
      end else if (k_ap_start) begin
        age++;
      end else begin
        age = 0;
      end
      if (k_ap_done && k_ap_continue && due_q.size() > 0) begin
        void'(due_q.pop_front());
        dn_n++;
      end
    end
  end

  always @(negedge ap_clk) begin
    cyc++;
    if (!ap_rst_n) begin
      k_ap_ready = 1'b0;
      k_ap_done = 1'b0;
    end else begin
      k_ap_ready = k_ap_start && (age >= rdy_dly);
      k_ap_done = (due_q.size() > 0) && (due_q[0] <= cyc);
    end
  end

  always @(negedge ap_clk) begin
    int mo;
    logic [31:0] cur;
    if (ap_rst_n) begin
      mo = iss_n - dn_n;
      cur = txn_issued - txn_done;
      if (done_pulse) pulse_cnt++;
      if (k_ap_start && mo >= 2) viol++;
      if (mo > 2 || mo < 0) viol++;
      if (cur != 32'(mo)) viol++;
      if (both_now) begin
        both_cnt++;
        if (cur != prev_out) viol++;
      end
      prev_out = cur;
    end
  end

  task automatic chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input string nm);
    int t;
    t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge ap_clk);
      t++;
    end
    if (!cmd_ready) chk({nm, "_ready_to"}, 0, 1);
  endtask

  task automatic wait_pulse(input string nm);
    int t;
    t = 0;
    while (!done_pulse && t < 300) begin
      @(negedge ap_clk);
      t++;
    end
    chk({nm, "_pulse_seen"}, done_pulse, 1);
  endtask

  task automatic set_kernel(input vec_t v);
    rdy_dly = v.rdy;
    dly[0] = v.d0;
    dly[1] = v.d1;
    dly[2] = v.d2;
    iss_base = iss_n;
  endtask

  task automatic run_row(input vec_t v, input string nm);
    int p0;
    int b0;
    set_kernel(v);
    wait_ready(nm);
    p0 = pulse_cnt;
    b0 = both_cnt;
    cmd_count = v.n;
    cmd_valid = 1'b1;
    @(negedge ap_clk);
    cmd_valid = 1'b0;
    wait_pulse(nm);
    chk({nm, "_issued"}, txn_issued, v.e_iss);
    chk({nm, "_done"}, txn_done, v.e_dn);
    chk({nm, "_last"}, last_latency, v.e_last);
    chk({nm, "_max"}, max_latency, v.e_max);
    @(negedge ap_clk);
    chk({nm, "_ready_after"}, cmd_ready, 1);
    repeat (3) @(negedge ap_clk);
    chk({nm, "_pulses"}, pulse_cnt - p0, 1);
    chk({nm, "_viol"}, viol, 0);
    if (v.both)
      chk({nm, "_both_evt"}, (both_cnt - b0) > 0, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{5, 1, 4, 4, 4, 5, 5, 4, 4, 1'b0};
    vecs[1] = '{6, 0, 2, 2, 2, 6, 6, 2, 2, 1'b1};
    vecs[2] = '{3, 1, 3, 7, 5, 3, 3, 5, 7, 1'b0};
    vecs[3] = '{1, 0, 1, 1, 1, 1, 1, 1, 1, 1'b0};
    vecs[4] = '{4, 2, 6, 6, 6, 4, 4, 6, 6, 1'b0};
    rv      = '{2, 1, 4, 4, 4, 2, 2, 4, 4, 1'b0};

    ap_rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_abort = 1'b0;
    cmd_count = '0;
    dly[0] = 1;
    dly[1] = 1;
    dly[2] = 1;

    repeat (2) @(negedge ap_clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_start", k_ap_start, 0);
    chk("rst_continue", k_ap_continue, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulse", done_pulse, 0);
    chk("rst_issued", txn_issued, 0);
    chk("rst_lat", {last_latency, max_latency}, 0);
    ap_rst_n = 1'b1;
    #1;
    chk("rel_ready_low", cmd_ready, 0);
    @(negedge ap_clk);
    chk("rel_ready_high", cmd_ready, 1);

    for (int i = 0; i < 5; i++)
      run_row(vecs[i], $sformatf("row%0d", i));

    // empty batch
    wait_ready("n0");
    cmd_count = 0;
    cmd_valid = 1'b1;
    @(negedge ap_clk);
    cmd_valid = 1'b0;
    chk("n0_c1_pulse", done_pulse, 0);
    chk("n0_c1_start", k_ap_start, 0);
    @(negedge ap_clk);
    chk("n0_c2_pulse", done_pulse, 1);
    chk("n0_c2_start", k_ap_start, 0);
    chk("n0_c2_issued", txn_issued, 0);
    @(negedge ap_clk);
    chk("n0_c3_ready", cmd_ready, 1);
    chk("n0_c3_pulse", done_pulse, 0);

    // abort while a start waits for a slow ready
    rv.rdy = 3;
    rv.d0 = 2;
    rv.d1 = 2;
    rv.d2 = 2;
    set_kernel(rv);
    wait_ready("ab");
    cmd_count = 5;
    cmd_valid = 1'b1;
    @(negedge ap_clk);
    cmd_valid = 1'b0;
    chk("ab_c1_start", k_ap_start, 1);
    cmd_abort = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      @(negedge ap_clk);
      chk($sformatf("ab_c%0d_start", i), k_ap_start, 1);
    end
    @(negedge ap_clk);
    chk("ab_c5_start", k_ap_start, 0);
    chk("ab_c5_busy", busy, 1);
    wait_pulse("ab");
    chk("ab_issued", txn_issued, 1);
    chk("ab_done", txn_done, 1);
    chk("ab_last", last_latency, 2);
    @(negedge ap_clk);
    cmd_abort = 1'b0;

    // reset in the middle of a batch
    rv = '{2, 1, 4, 4, 4, 2, 2, 4, 4, 1'b0};
    set_kernel(rv);
    wait_ready("mr");
    cmd_count = 5;
    cmd_valid = 1'b1;
    @(negedge ap_clk);
    cmd_valid = 1'b0;
    repeat (7) @(negedge ap_clk);
    chk("mr_busy_pre", busy, 1);
    chk("mr_issued_pre", txn_issued != 0, 1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("mr_start", k_ap_start, 0);
    chk("mr_continue", k_ap_continue, 0);
    chk("mr_busy", busy, 0);
    chk("mr_ready", cmd_ready, 0);
    chk("mr_pulse", done_pulse, 0);
    chk("mr_issued", txn_issued, 0);
    chk("mr_done", txn_done, 0);
    chk("mr_lat", {last_latency, max_latency}, 0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("mr_ready_back", cmd_ready, 1);
    run_row(rv, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
